escrita_framebuffer: RTL and testbench
======================================

Name: escrita_framebuffer

Overview:
- Downstream stage of escolha_algoritmo: consumes the scaled pixel stream (out_pixel/done) and writes it, raster order, into the output frame-buffer RAM read by the display path.
- Generates x/y counters and a linear RAM address, handshakes with the producer, flags frame completion and short frames.

Parameters:
OUT_W, 8, output image width in pixels (4x4 source scaled 2x)
OUT_H, 8, output image height in lines
PIXEL_W, 8, pixel width in bits
ADDR_W, 6, RAM address width; must satisfy 2**ADDR_W >= OUT_W*OUT_H

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  pulse: arm capture of one frame
in_pixel  input  PIXEL_W  pixel from escolha_algoritmo out_pixel
in_valid  input  1  in_pixel valid this cycle
in_ready  output  1  block accepts a pixel this cycle
src_done  input  1  producer done flag (escolha_algoritmo done)
mem_addr  output  ADDR_W (+1 with DOUBLE_BUFFER_EN)  RAM write address
mem_data  output  PIXEL_W  RAM write data
mem_we  output  1  RAM write enable
busy  output  1  high in WRITE state
frame_done  output  1  one-cycle pulse: full frame written
short_err  output  1  sticky: src_done seen before frame complete
pix_count  output  ADDR_W+1  pixels accepted in current/last frame

Behaviour:
- Reset (async, rst_n=0): state IDLE; x=0, y=0; in_ready, mem_we, busy, frame_done, short_err = 0; mem_addr, mem_data, pix_count = 0.
- Handshake: pixel accepted on rising edge when in_valid && in_ready. in_ready = 1 only in WRITE (combinational from state).
- Write port registered: accepted pixel appears as mem_we=1, mem_addr=y*OUT_W+x, mem_data=in_pixel exactly 1 cycle after acceptance; mem_we=0 in all other cycles. mem_addr/mem_data hold last value when mem_we=0.
- Counters: on accept, x increments; at x=OUT_W-1, x wraps to 0 and y increments. pix_count increments per accept, saturates at OUT_W*OUT_H.
- FSM:
  - IDLE: start=1 -> WRITE; clears x, y, pix_count, short_err.
  - WRITE: busy=1. Accept at x=OUT_W-1, y=OUT_H-1 -> DONE (in_ready drops next cycle; extra pixels not accepted). src_done=1 without a same-cycle final accept -> short_err=1, -> IDLE (no frame_done).
  - DONE: frame_done=1 for this single cycle (coincides with the final mem_we), -> IDLE.
- start outside IDLE ignored. start and src_done together in IDLE: start wins, short_err not set.
- in_valid low in WRITE: counters hold, no write; bubbles of any length allowed.
- Reset mid-frame: immediate return to IDLE, pending write dropped (mem_we=0 while rst_n=0).
- Address arithmetic in ADDR_W bits; y*OUT_W+x never exceeds OUT_W*OUT_H-1.

Optional Feature:
- Macro DOUBLE_BUFFER_EN.
- Defined: internal bank bit, reset 0; mem_addr = {bank, y*OUT_W+x} (ADDR_W+1 bits). bank toggles in the frame_done cycle, so consecutive frames alternate RAM halves; display side reads ~bank. Short frame does not toggle bank.
- Undefined: no bank bit, mem_addr is ADDR_W bits, every frame overwrites the same region.

Test Plan:
- Reset, start, 64 consecutive valid pixels 0..63 -> mem_we 64 cycles, mem_addr k carries data k, frame_done one pulse aligned with addr 63 write, pix_count=64, busy low after.
- Same frame, in_valid low every other cycle -> identical RAM contents, no write in gap cycles, frame_done after 127 cycles of WRITE.
- 70 valid pixels after start -> only first 64 accepted, in_ready 0 after the 64th, no addr wrap to 0.
- src_done after 20 pixels -> short_err=1, state IDLE, no frame_done; next start clears short_err and restarts at addr 0.
- rst_n low after 30 pixels -> mem_we=0 immediately, all outputs at reset values; start then 64 pixels -> addresses from 0.
- DOUBLE_BUFFER_EN: two full frames -> first at 0..63, second at 64..127; frame_done toggles bank each time.

Source files
------------

// File: rtl/escrita_framebuffer.sv
// escrita_framebuffer
// Writes the scaled pixel stream from escolha_algoritmo into the output
// frame-buffer RAM in raster order. The block generates x/y counters, a
// linear RAM address and a registered write port. It pulses frame_done when
// a full frame has been written. It raises a sticky short_err when the
// producer signals done before the frame is complete.
//
// Optional feature: define DOUBLE_BUFFER_EN to prepend a bank bit to
// mem_addr. The bank bit toggles after every complete frame, so
// consecutive frames land in alternate halves of the RAM.
module escrita_framebuffer #(
   parameter int OUT_W   = 8,
   parameter int OUT_H   = 8,
   parameter int PIXEL_W = 8,
   parameter int ADDR_W  = 6
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [PIXEL_W-1:0]   in_pixel,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 src_done,
`ifdef DOUBLE_BUFFER_EN
   output logic [ADDR_W:0]      mem_addr,
`else
   output logic [ADDR_W-1:0]    mem_addr,
`endif
   output logic [PIXEL_W-1:0]   mem_data,
   output logic                 mem_we,
   output logic                 busy,
   output logic                 frame_done,
   output logic                 short_err,
   output logic [ADDR_W:0]      pix_count
);

   localparam int X_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;
   localparam int Y_W = (OUT_H > 1) ? $clog2(OUT_H) : 1;

   localparam logic [X_W-1:0]    LP_X_LAST  = X_W'(OUT_W - 1);
   localparam logic [Y_W-1:0]    LP_Y_LAST  = Y_W'(OUT_H - 1);
   localparam logic [X_W-1:0]    LP_X_ONE   = X_W'(1);
   localparam logic [Y_W-1:0]    LP_Y_ONE   = Y_W'(1);
   localparam logic [ADDR_W-1:0] LP_LINE    = ADDR_W'(OUT_W);
   localparam logic [ADDR_W:0]   LP_FRAME   = (ADDR_W + 1)'(OUT_W * OUT_H);
   localparam logic [ADDR_W:0]   LP_PIX_ONE = (ADDR_W + 1)'(1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t               r_state;
   logic [X_W-1:0]       r_x;
   logic [Y_W-1:0]       r_y;
   logic [ADDR_W:0]      r_pix_count;
   logic                 r_mem_we;
   logic [PIXEL_W-1:0]   r_mem_data;
   logic                 r_busy;
   logic                 r_frame_done;
   logic                 r_short_err;
`ifdef DOUBLE_BUFFER_EN
   logic                 r_bank;
   logic [ADDR_W:0]      r_mem_addr;
`else
   logic [ADDR_W-1:0]    r_mem_addr;
`endif

   logic                 w_in_ready;
   logic                 w_accept;
   logic                 w_x_last;
   logic                 w_y_last;
   logic                 w_last_accept;
   logic                 w_arm;
   logic [ADDR_W-1:0]    w_lin_addr;
   logic [ADDR_W:0]      w_pix_next;

   // The block is ready exactly while the FSM sits in WRITE; it never stalls mid-frame.
   assign w_in_ready    = (r_state == ST_WRITE);
   assign w_accept      = in_valid & w_in_ready;
   assign w_x_last      = (r_x == LP_X_LAST);
   assign w_y_last      = (r_y == LP_Y_LAST);
   assign w_last_accept = w_accept & w_x_last & w_y_last;
   assign w_arm         = (r_state == ST_IDLE) & start;

   // The counters never point past the last pixel, so this cannot overflow ADDR_W.
   assign w_lin_addr    = (ADDR_W'(r_y) * LP_LINE) + ADDR_W'(r_x);

   // The pixel count saturates at one full frame.
   assign w_pix_next    = (r_pix_count == LP_FRAME) ? r_pix_count
                                                    : (r_pix_count + LP_PIX_ONE);

   // The frame sequencer updates the state, the busy/frame_done/short_err flags and the bank bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_busy       <= 1'b0;
         r_frame_done <= 1'b0;
         r_short_err  <= 1'b0;
`ifdef DOUBLE_BUFFER_EN
         r_bank       <= 1'b0;
`endif
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_frame_done <= 1'b0;
               // start has priority over src_done here; a stale done cannot flag an error.
               if (start) begin
                  r_state     <= ST_WRITE;
                  r_busy      <= 1'b1;
                  r_short_err <= 1'b0;
               end else begin
                  r_state     <= ST_IDLE;
                  r_busy      <= 1'b0;
               end
            end
            ST_WRITE: begin
               if (w_last_accept) begin
                  // frame_done goes high together with the final registered write.
                  r_state      <= ST_DONE;
                  r_busy       <= 1'b0;
                  r_frame_done <= 1'b1;
               end else if (src_done) begin
                  r_state      <= ST_IDLE;
                  r_busy       <= 1'b0;
                  r_frame_done <= 1'b0;
                  r_short_err  <= 1'b1;
               end else begin
                  r_state      <= ST_WRITE;
                  r_busy       <= 1'b1;
                  r_frame_done <= 1'b0;
               end
            end
            ST_DONE: begin
               r_state      <= ST_IDLE;
               r_busy       <= 1'b0;
               r_frame_done <= 1'b0;
`ifdef DOUBLE_BUFFER_EN
               // The final write already holds the old bank; the next frame uses the other half.
               r_bank       <= ~r_bank;
`endif
            end
            default: begin
               r_state      <= ST_IDLE;
               r_busy       <= 1'b0;
               r_frame_done <= 1'b0;
            end
         endcase
      end
   end

   // The raster counters and the saturating accepted-pixel count clear on arm and advance on accept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_x         <= {X_W{1'b0}};
         r_y         <= {Y_W{1'b0}};
         r_pix_count <= {(ADDR_W + 1){1'b0}};
      end else if (w_arm) begin
         r_x         <= {X_W{1'b0}};
         r_y         <= {Y_W{1'b0}};
         r_pix_count <= {(ADDR_W + 1){1'b0}};
      end else if (w_accept) begin
         r_pix_count <= w_pix_next;
         if (w_x_last) begin
            r_x <= {X_W{1'b0}};
            if (w_y_last) begin
               r_y <= {Y_W{1'b0}};
            end else begin
               r_y <= r_y + LP_Y_ONE;
            end
         end else begin
            r_x <= r_x + LP_X_ONE;
            r_y <= r_y;
         end
      end else begin
         r_x         <= r_x;
         r_y         <= r_y;
         r_pix_count <= r_pix_count;
      end
   end

   // The registered RAM write port issues one write per accepted pixel; address and data hold otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mem_we   <= 1'b0;
         r_mem_data <= {PIXEL_W{1'b0}};
`ifdef DOUBLE_BUFFER_EN
         r_mem_addr <= {(ADDR_W + 1){1'b0}};
`else
         r_mem_addr <= {ADDR_W{1'b0}};
`endif
      end else if (w_accept) begin
         r_mem_we   <= 1'b1;
         r_mem_data <= in_pixel;
`ifdef DOUBLE_BUFFER_EN
         r_mem_addr <= {r_bank, w_lin_addr};
`else
         r_mem_addr <= w_lin_addr;
`endif
      end else begin
         r_mem_we   <= 1'b0;
         r_mem_data <= r_mem_data;
         r_mem_addr <= r_mem_addr;
      end
   end

   assign in_ready   = w_in_ready;
   assign mem_we     = r_mem_we;
   assign mem_addr   = r_mem_addr;
   assign mem_data   = r_mem_data;
   assign busy       = r_busy;
   assign frame_done = r_frame_done;
   assign short_err  = r_short_err;
   assign pix_count  = r_pix_count;

endmodule

// File: tb/tb_escrita_framebuffer.sv
// Self-checking bench for escrita_framebuffer. Expected RAM writes are queued
// as pixels are driven. A negedge monitor pops each entry and compares it
// against the write port. Scenario tasks check the status outputs inline.
module tb_escrita_framebuffer;

   localparam int OUT_W   = 8;
   localparam int OUT_H   = 8;
   localparam int PIXEL_W = 8;
   localparam int ADDR_W  = 6;
   localparam int NPIX    = OUT_W * OUT_H;
`ifdef DOUBLE_BUFFER_EN
   localparam int MA_W    = ADDR_W + 1;
`else
   localparam int MA_W    = ADDR_W;
`endif

   typedef struct packed {
      logic [MA_W-1:0]    addr;
      logic [PIXEL_W-1:0] data;
      logic               last;
   } exp_t;

   exp_t sb_q[$];

   logic               clk      = 1'b0;
   logic               rst_n    = 1'b0;
   logic               start    = 1'b0;
   logic [PIXEL_W-1:0] in_pixel = '0;
   logic               in_valid = 1'b0;
   logic               src_done = 1'b0;
   logic               in_ready;
   logic [MA_W-1:0]    mem_addr;
   logic [PIXEL_W-1:0] mem_data;
   logic               mem_we;
   logic               busy;
   logic               frame_done;
   logic               short_err;
   logic [ADDR_W:0]    pix_count;

   int checks      = 0;
   int errors      = 0;
   int fd_count    = 0;
   int busy_cycles = 0;
   int write_count = 0;
   logic tb_bank   = 1'b0;

   escrita_framebuffer #(
      .OUT_W(OUT_W), .OUT_H(OUT_H), .PIXEL_W(PIXEL_W), .ADDR_W(ADDR_W)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .in_pixel(in_pixel),
      .in_valid(in_valid), .in_ready(in_ready), .src_done(src_done),
      .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we),
      .busy(busy), .frame_done(frame_done), .short_err(short_err),
      .pix_count(pix_count)
   );

   always #5 clk = ~clk;

   // Scoreboard monitor: every write must match the head of the expected queue.
   always @(negedge clk) begin
      exp_t e;
      if (busy === 1'b1) busy_cycles++;
      if (frame_done === 1'b1) fd_count++;
      if (mem_we === 1'b1) begin
         write_count++;
         checks++;
         if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write addr=%0d data=%0d", mem_addr, mem_data);
         end else begin
            e = sb_q.pop_front();
            if (mem_addr !== e.addr || mem_data !== e.data || frame_done !== e.last) begin
               errors++;
               $display("FAIL write got addr=%0d data=%0d fd=%b exp addr=%0d data=%0d fd=%b",
                        mem_addr, mem_data, frame_done, e.addr, e.data, e.last);
            end
         end
      end else if (frame_done !== 1'b0) begin
         checks++;
         errors++;
         $display("FAIL frame_done_without_write fd=%b exp 0", frame_done);
      end
   end

   // Watchdog keeps the run bounded.
   initial begin
      #300000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic pulse_start(input logic with_done);
      start    = 1'b1;
      src_done = with_done;
      @(posedge clk); #1;
      start    = 1'b0;
      src_done = 1'b0;
   endtask

   // Drive n_pix valid pixels (optionally with one idle gap between them); queue the first n_acc.
   task automatic drive_frame(input int n_pix, input int gap, input int n_acc, input int seed);
      exp_t e;
      for (int k = 0; k < n_pix; k++) begin
         in_valid = 1'b1;
         in_pixel = PIXEL_W'(k + seed);
         if (k < n_acc) begin
`ifdef DOUBLE_BUFFER_EN
            e.addr = {tb_bank, k[ADDR_W-1:0]};
`else
            e.addr = k[ADDR_W-1:0];
`endif
            e.data = PIXEL_W'(k + seed);
            e.last = (k == NPIX - 1);
            sb_q.push_back(e);
         end
         @(posedge clk); #1;
         if (gap != 0 && k != n_pix - 1) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic test_reset;
      #12;
      checks++;
      if (in_ready !== 1'b0 || mem_we !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0 ||
          short_err !== 1'b0 || mem_addr !== '0 || mem_data !== '0 || pix_count !== '0) begin
         errors++;
         $display("FAIL reset_state rdy=%b we=%b busy=%b fd=%b se=%b addr=%0d data=%0d cnt=%0d exp all 0",
                  in_ready, mem_we, busy, frame_done, short_err, mem_addr, mem_data, pix_count);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_full_frame(input int seed);
      int fd0, wc0, bc0;
      fd0 = fd_count; wc0 = write_count; bc0 = busy_cycles;
      pulse_start(1'b0);
      drive_frame(NPIX, 0, NPIX, seed);
      repeat (3) @(posedge clk);
      #1;
      tb_bank = ~tb_bank;
      checks++;
      if (sb_q.size() != 0) begin errors++; $display("FAIL full_drain left=%0d exp 0", sb_q.size()); end
      checks++;
      if (write_count - wc0 != NPIX) begin errors++; $display("FAIL full_writes got=%0d exp %0d", write_count - wc0, NPIX); end
      checks++;
      if (fd_count - fd0 != 1) begin errors++; $display("FAIL full_frame_done got=%0d exp 1", fd_count - fd0); end
      checks++;
      if (pix_count !== 7'd64) begin errors++; $display("FAIL full_pix_count got=%0d exp 64", pix_count); end
      checks++;
      if (busy !== 1'b0 || busy_cycles - bc0 != NPIX) begin
         errors++; $display("FAIL full_busy got=%b cycles=%0d exp 0 cycles=%0d", busy, busy_cycles - bc0, NPIX);
      end
   endtask

   task automatic test_bubbles;
      int fd0, wc0, bc0;
      fd0 = fd_count; wc0 = write_count; bc0 = busy_cycles;
      pulse_start(1'b0);
      drive_frame(NPIX, 1, NPIX, 0);
      repeat (3) @(posedge clk);
      #1;
      tb_bank = ~tb_bank;
      checks++;
      if (sb_q.size() != 0) begin errors++; $display("FAIL bubble_drain left=%0d exp 0", sb_q.size()); end
      checks++;
      if (write_count - wc0 != NPIX) begin errors++; $display("FAIL bubble_writes got=%0d exp %0d", write_count - wc0, NPIX); end
      checks++;
      if (fd_count - fd0 != 1) begin errors++; $display("FAIL bubble_frame_done got=%0d exp 1", fd_count - fd0); end
      checks++;
      if (busy_cycles - bc0 != 2 * NPIX - 1) begin
         errors++; $display("FAIL bubble_write_cycles got=%0d exp %0d", busy_cycles - bc0, 2 * NPIX - 1);
      end
   endtask

   task automatic test_overrun;
      int fd0, wc0;
      fd0 = fd_count; wc0 = write_count;
      pulse_start(1'b0);
      drive_frame(NPIX + 6, 0, NPIX, 100);
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL overrun_in_ready got=%b exp 0", in_ready); end
      repeat (3) @(posedge clk);
      #1;
      tb_bank = ~tb_bank;
      checks++;
      if (write_count - wc0 != NPIX || sb_q.size() != 0) begin
         errors++; $display("FAIL overrun_writes got=%0d left=%0d exp %0d left=0", write_count - wc0, sb_q.size(), NPIX);
      end
      checks++;
      if (fd_count - fd0 != 1 || pix_count !== 7'd64) begin
         errors++; $display("FAIL overrun_status fd=%0d cnt=%0d exp fd=1 cnt=64", fd_count - fd0, pix_count);
      end
   endtask

   task automatic test_short;
      int fd0;
      fd0 = fd_count;
      pulse_start(1'b0);
      drive_frame(20, 0, 20, 50);
      src_done = 1'b1;
      @(posedge clk); #1;
      src_done = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (short_err !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0) begin
         errors++; $display("FAIL short_flags se=%b busy=%b rdy=%b exp se=1 busy=0 rdy=0", short_err, busy, in_ready);
      end
      checks++;
      if (fd_count != fd0 || pix_count !== 7'd20 || sb_q.size() != 0) begin
         errors++; $display("FAIL short_status fd=%0d cnt=%0d left=%0d exp fd=0 cnt=20 left=0", fd_count - fd0, pix_count, sb_q.size());
      end
      // Restart with start and src_done together: start wins and clears the error.
      pulse_start(1'b1);
      checks++;
      if (short_err !== 1'b0 || busy !== 1'b1 || pix_count !== 7'd0) begin
         errors++; $display("FAIL short_restart se=%b busy=%b cnt=%0d exp se=0 busy=1 cnt=0", short_err, busy, pix_count);
      end
      drive_frame(NPIX, 0, NPIX, 7);
      repeat (3) @(posedge clk);
      #1;
      tb_bank = ~tb_bank;
      checks++;
      if (fd_count - fd0 != 1 || sb_q.size() != 0) begin
         errors++; $display("FAIL short_refill fd=%0d left=%0d exp fd=1 left=0", fd_count - fd0, sb_q.size());
      end
   endtask

   task automatic test_reset_mid;
      pulse_start(1'b0);
      // The 30th pixel is accepted, but reset drops its write before it can be seen.
      drive_frame(30, 0, 29, 200);
      rst_n = 1'b0;
      #1;
      checks++;
      if (mem_we !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0 || frame_done !== 1'b0 ||
          short_err !== 1'b0 || mem_addr !== '0 || mem_data !== '0 || pix_count !== '0) begin
         errors++;
         $display("FAIL midreset_state we=%b busy=%b rdy=%b fd=%b se=%b addr=%0d data=%0d cnt=%0d exp all 0",
                  mem_we, busy, in_ready, frame_done, short_err, mem_addr, mem_data, pix_count);
      end
      tb_bank = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      checks++;
      if (sb_q.size() != 0) begin errors++; $display("FAIL midreset_drain left=%0d exp 0", sb_q.size()); end
      @(posedge clk); #1;
      test_full_frame(9);
   endtask

`ifdef DOUBLE_BUFFER_EN
   task automatic test_double_buffer;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n   = 1'b1;
      tb_bank = 1'b0;
      @(posedge clk); #1;
      test_full_frame(11);
      test_full_frame(22);
      checks++;
      if (tb_bank !== 1'b0) begin errors++; $display("FAIL dbuf_bank_model got=%b exp 0", tb_bank); end
   endtask
`endif

   initial begin
      test_reset();
      test_full_frame(0);
      test_bubbles();
      test_overrun();
      test_short();
      test_reset_mid();
`ifdef DOUBLE_BUFFER_EN
      test_double_buffer();
`endif
      repeat (2) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
